// File: rtl/dmem_ctrl.sv
// Data-memory controller: single outstanding access with a fixed wait count,
// byte/half/word lanes, sign/zero-extended loads and misalignment/range faults.
module dmem_ctrl #(
  parameter int    DW        = 32,
  parameter int    DEPTH     = 256,
  parameter int    WAIT      = 2,
  parameter string INIT_FILE = ""
) (
  input  logic          t4,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [31:0]   addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          err,
  output logic          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, next_state;
  logic [3:0]  cnt, cnt_d;
  logic        accept, enter_done;

  logic        we_q, uns_q, fault_q, load_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_word;

  // With WAIT=0 the DONE-entry edge is the accept edge, so the access fields
  // come straight from the ports in IDLE and from the capture registers after.
  logic          cur_we;
  logic [1:0]    cur_size;
  logic [31:0]   cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [AW-1:0] cur_idx;
  logic          fault;

  always_comb begin
    if (state == S_IDLE) begin
      cur_we    = we;
      cur_size  = size;
      cur_addr  = addr;
      cur_wdata = wdata;
    end else begin
      cur_we    = we_q;
      cur_size  = size_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign cur_idx = cur_addr[AW+1:2];
  assign fault   = (cur_size == 2'b11)
                 | ((cur_size == 2'b01) & cur_addr[0])
                 | ((cur_size == 2'b10) & (cur_addr[1:0] != 2'b00))
                 | ((cur_addr >> (AW + 2)) != 32'd0);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    accept     = 1'b0;
    enter_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT == 0) begin
            next_state = S_DONE;
            enter_done = 1'b1;
          end else begin
            next_state = S_WAIT;
            cnt_d      = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          next_state = S_DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge t4 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= cnt_d;
    end
  end

  // Store merge: replicate the right-aligned data across lanes, then enable only the addressed ones.
  logic [31:0] wsrc, old_word, merged;
  logic [3:0]  be;

  always_comb begin
    old_word = 32'(mem[cur_idx]);
    case (cur_size)
      2'b00: begin
        wsrc = {4{cur_wdata[7:0]}};
        be   = 4'b0001 << cur_addr[1:0];
      end
      2'b01: begin
        wsrc = {2{cur_wdata[15:0]}};
        be   = 4'b0011 << {cur_addr[1], 1'b0};
      end
      default: begin
        wsrc = 32'(cur_wdata);
        be   = 4'b1111;
      end
    endcase
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wsrc[8*i +: 8];
    end
  end

  // NOTE: the memory array has no reset; its contents survive rst_n.
  always_ff @(posedge t4) begin
    if (enter_done && rst_n) begin
      if (cur_we && !fault) mem[cur_idx] <= merged[DW-1:0];
      rd_word <= mem[cur_idx];
    end
  end

  // Load extraction from the word captured on DONE entry.
  logic [31:0] rd_wide, rd_shift, load_val;

  always_comb begin
    rd_wide  = 32'(rd_word);
    rd_shift = 32'd0;
    load_val = 32'd0;
    case (size_q)
      2'b00: begin
        rd_shift = rd_wide >> {addr_q[1:0], 3'b000};
        load_val = uns_q ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      2'b01: begin
        rd_shift = rd_wide >> {addr_q[1], 4'b0000};
        load_val = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      2'b10:   load_val = rd_wide;
      default: load_val = 32'd0;
    endcase
  end

  always_ff @(posedge t4 or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      load_q  <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        size_q  <= size;
        uns_q   <= uns;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (enter_done) begin
        fault_q <= fault;
        load_q  <= !cur_we;
      end
      if (state == S_DONE) begin
        ready <= 1'b1;
        err   <= fault_q;
        if (fault_q)     rdata <= '0;
        else if (load_q) rdata <= load_val[DW-1:0];
      end else begin
        ready <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (DW=32, DEPTH=256, WAIT=2): vector table of
// accesses plus hand sequences for held req and reset during an access.
module tb_dmem_ctrl;

  localparam int WAIT  = 2;
  localparam int DEPTH = 256;

  logic        t4, rst_n, req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_ctrl #(.DW(32), .DEPTH(DEPTH), .WAIT(WAIT), .INIT_FILE("")) dut (
    .t4(t4), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  initial t4 = 1'b0;
  always #5 t4 = ~t4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One access: drive on the falling edge, count cycles from the accept edge to ready.
  task automatic do_access(input string name, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rdata, input logic exp_err);
    int cycles;
    @(negedge t4);
    we = w; size = sz; uns = u; addr = a; wdata = wd; req = 1'b1;
    @(posedge t4);
    #1 req = 1'b0;
    cycles = 0;
    do begin
      @(posedge t4);
      #1 cycles++;
      if (cycles == 1) check({name, " busy"}, 32'(busy), 32'd1);
    end while (!ready && cycles < 20);
    check({name, " latency"}, 32'(cycles), 32'(WAIT + 1));
    check({name, " rdata"}, rdata, exp_rdata);
    check({name, " err"}, 32'(err), 32'(exp_err));
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{"sw 8",      1'b1, 2'b10, 1'b0, 32'h8,   32'h11223344, 32'h00000000, 1'b0};
    vecs[1]  = '{"lw 8",      1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        32'h11223344, 1'b0};
    vecs[2]  = '{"sb 9",      1'b1, 2'b00, 1'b0, 32'h9,   32'h000000AB, 32'h11223344, 1'b0};
    vecs[3]  = '{"lb 9",      1'b0, 2'b00, 1'b0, 32'h9,   32'h0,        32'hFFFFFFAB, 1'b0};
    vecs[4]  = '{"lbu 9",     1'b0, 2'b00, 1'b1, 32'h9,   32'h0,        32'h000000AB, 1'b0};
    vecs[5]  = '{"lw 8 b",    1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        32'h1122AB44, 1'b0};
    vecs[6]  = '{"sh A",      1'b1, 2'b01, 1'b0, 32'hA,   32'h00008001, 32'h1122AB44, 1'b0};
    vecs[7]  = '{"lh A",      1'b0, 2'b01, 1'b0, 32'hA,   32'h0,        32'hFFFF8001, 1'b0};
    vecs[8]  = '{"lhu A",     1'b0, 2'b01, 1'b1, 32'hA,   32'h0,        32'h00008001, 1'b0};
    vecs[9]  = '{"lw 8 c",    1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        32'h8001AB44, 1'b0};
    vecs[10] = '{"lw 6 mis",  1'b0, 2'b10, 1'b0, 32'h6,   32'h0,        32'h00000000, 1'b1};
    vecs[11] = '{"sh 3 mis",  1'b1, 2'b01, 1'b0, 32'h3,   32'h0000FFFF, 32'h00000000, 1'b1};
    vecs[12] = '{"sw range",  1'b1, 2'b10, 1'b0, 32'h400, 32'h55555555, 32'h00000000, 1'b1};
    vecs[13] = '{"size 11",   1'b0, 2'b11, 1'b0, 32'h8,   32'h0,        32'h00000000, 1'b1};
    vecs[14] = '{"lw 8 d",    1'b0, 2'b10, 1'b0, 32'h8,   32'h0,        32'h8001AB44, 1'b0};
    vecs[15] = '{"sw 3FC",    1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, 32'h8001AB44, 1'b0};
    vecs[16] = '{"lbu 3FF",   1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0,        32'h000000CA, 1'b0};
    vecs[17] = '{"lb 3FE",    1'b0, 2'b00, 1'b0, 32'h3FE, 32'h0,        32'hFFFFFFFE, 1'b0};
    vecs[18] = '{"lh 3FC",    1'b0, 2'b01, 1'b0, 32'h3FC, 32'h0,        32'hFFFFF00D, 1'b0};
    vecs[19] = '{"lhu 8",     1'b0, 2'b01, 1'b1, 32'h8,   32'h0,        32'h0000AB44, 1'b0};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    #1;
    check("reset ready", 32'(ready), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rdata", rdata, 32'd0);
    @(posedge t4);
    @(posedge t4);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      do_access(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // req held high: one access every WAIT+2 cycles, ready on the last of each period.
    @(negedge t4);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h8; req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge t4);
      #1;
      check($sformatf("held busy %0d", k), 32'(busy), 32'((k % (WAIT + 2)) != WAIT + 1));
      check($sformatf("held ready %0d", k), 32'(ready), 32'((k % (WAIT + 2)) == WAIT + 1));
      if ((k % (WAIT + 2)) == WAIT + 1) check($sformatf("held rdata %0d", k), rdata, 32'h8001AB44);
    end
    @(negedge t4);
    req = 1'b0;

    // Reset during the WAIT phase of a store aborts it.
    @(negedge t4);
    we = 1'b1; size = 2'b10; addr = 32'h8; wdata = 32'hDEADBEEF; req = 1'b1;
    @(posedge t4);
    #1 req = 1'b0;
    @(posedge t4);
    #1;
    check("abort busy pre", 32'(busy), 32'd1);
    check("abort rdata pre", rdata, 32'h8001AB44);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort rdata", rdata, 32'd0);
    check("abort ready", 32'(ready), 32'd0);
    check("abort err", 32'(err), 32'd0);
    @(posedge t4);
    @(posedge t4);
    #1;
    check("abort ready held", 32'(ready), 32'd0);
    rst_n = 1'b1;
    do_access("lw after abort", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h8001AB44, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
